// File: rtl/gf180mcu_fd_sc_mcu9t5v0__capbank_pkg.sv
// ----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__capbank_pkg : sequencer states and level decoder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gf180mcu_fd_sc_mcu9t5v0__capbank_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  // Low lvl bits set, clipped to the bank count (at most 16 banks).
  function automatic logic [15:0] lvl2therm(input int unsigned lvl, input int unsigned nbank);
    logic [15:0] therm;
    therm = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      therm[i] = (i < lvl) && (i < nbank);
    end
    return therm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__capbank_dwell.sv
// ----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__capbank_dwell : loadable dwell down-counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__capbank_dwell
  import gf180mcu_fd_sc_mcu9t5v0__capbank_pkg::*;
#(
  parameter int DWELL = 8,
  parameter int CW    = 8
) (
`ifdef USE_POWER_PINS
  inout wire  VDD,
  inout wire  VSS,
`endif
  input  logic CLK,
  input  logic RN,
  input  logic LOAD,
  output logic TC
);

  localparam logic [CW-1:0] RELOAD  = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter parks at zero, so TC stays high outside a ramp.
  always_comb begin
    cnt_d = cnt_q;
    if (LOAD) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign TC = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__capbank_seq.sv
// ----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__capbank_seq : staged decap-bank enable sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__capbank_seq
  import gf180mcu_fd_sc_mcu9t5v0__capbank_pkg::*;
#(
  parameter int NBANK = 4,
  parameter int DWELL = 8,
  parameter int CW    = 8
) (
`ifdef USE_POWER_PINS
  inout wire               VDD,
  inout wire               VSS,
`endif
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  output logic [NBANK-1:0] BANK_EN,
  output logic             READY,
  output logic             BUSY
);

  localparam int            LW      = $clog2(NBANK + 1);
  localparam logic [LW-1:0] LVL_TOP = LW'(NBANK);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  state_e            state_q;
  state_e            state_d;
  logic [LW-1:0]     lvl_q;
  logic [LW-1:0]     lvl_d;
  logic              load_d;
  logic              tc;
  logic [NBANK-1:0]  therm_d;

  gf180mcu_fd_sc_mcu9t5v0__capbank_dwell #(
    .DWELL (DWELL),
    .CW    (CW)
  ) u_dwell (
`ifdef USE_POWER_PINS
    .VDD  (VDD),
    .VSS  (VSS),
`endif
    .CLK  (CLK),
    .RN   (RN),
    .LOAD (load_d),
    .TC   (tc)
  );

  // Reversals take priority over a pending step; every level change reloads the dwell.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    load_d  = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (EN) begin
          state_d = ST_RAMP_UP;
          lvl_d   = LVL_ONE;
          load_d  = 1'b1;
        end
      end
      ST_RAMP_UP: begin
        if (lvl_q == LVL_TOP) begin
          // Only reachable with a single bank: the ramp state lasts one edge.
          if (EN) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_RAMP_DOWN;
            lvl_d   = LVL_TOP - LVL_ONE;
            load_d  = 1'b1;
          end
        end else if (!EN) begin
          state_d = ST_RAMP_DOWN;
          load_d  = 1'b1;
        end else if (tc) begin
          lvl_d  = lvl_q + LVL_ONE;
          load_d = 1'b1;
          if (lvl_d == LVL_TOP) state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (!EN) begin
          state_d = ST_RAMP_DOWN;
          lvl_d   = LVL_TOP - LVL_ONE;
          load_d  = 1'b1;
        end
      end
      ST_RAMP_DOWN: begin
        if (lvl_q == '0) begin
          if (!EN) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_RAMP_UP;
            lvl_d   = LVL_ONE;
            load_d  = 1'b1;
          end
        end else if (EN) begin
          state_d = ST_RAMP_UP;
          load_d  = 1'b1;
        end else if (tc) begin
          lvl_d  = lvl_q - LVL_ONE;
          load_d = 1'b1;
          if (lvl_d == '0) state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        lvl_d   = '0;
      end
    endcase
  end

  assign therm_d = NBANK'(lvl2therm(32'(lvl_d), NBANK));

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= ST_OFF;
      lvl_q   <= '0;
      BANK_EN <= '0;
      READY   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      BANK_EN <= therm_d;
      READY   <= (state_d == ST_ON);
      BUSY    <= (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
    end
  end

endmodule

`default_nettype wire
